// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow of a single bit position
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// behind a valid/ready handshake on both the operand and result sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             cell_d, cell_bout;

  // Single shared bit cell fed by the operand shift-register LSBs
  full_subtractor u_cell (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .bin (br_q),
    .d   (cell_d),
    .bout(cell_bout)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = cell_bout;
        diff_d = WIDTH'({cell_d, diff_q} >> 1);
        cnt_d  = cnt_q + CNT_W'(1);
        // Last step: the cell is looking at the operand MSBs
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          bout_d  = cell_bout;
          ovf_d   = (a_q[0] != b_q[0]) && (cell_d != a_q[0]);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == RUN);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;

  int   errors = 0;
  int   checks = 0;
  bit   rand_rdy = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare observed against expected and count
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full-width unsigned subtraction
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t       e;
    logic [W:0] full;
    full   = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
    return e;
  endfunction

  // Advance one cycle and settle; optionally randomise out_ready
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Wait for in_ready, present one operand set for a single edge
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      check("in_ready_wait", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    a        = x;
    b        = y;
    bin      = bi;
    if (push) sb_q.push_back(model(x, y, bi));
    step();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom_range(0, 1));
  endtask

  // Scoreboard consumer: compare at each result handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("diff", 32'(diff), 32'(mon_e.diff));
        check("bout", 32'(bout), 32'(mon_e.bout));
        check("ovf",  32'(ovf),  32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   busy_cnt;
    int   n;
    exp_t st;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_bout",      32'(bout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    repeat (3) step();
    rst = 1'b0;

    // Basic op straight out of reset, with latency and busy-length checks
    issue(8'h5A, 8'h3C, 1'b0, 1);
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 50) begin
      busy_cnt += int'(busy);
      step();
      lat++;
    end
    check("latency",   32'(lat),      32'd8);
    check("busy_len",  32'(busy_cnt), 32'd8);
    check("dir_diff",  32'(diff),     32'h1E);
    check("dir_busy0", 32'(busy),     32'd0);
    step();
    check("consume_1st_edge", 32'(out_valid), 32'd0);

    // Boundary operand sets
    issue(8'h00, 8'h01, 1'b0, 1);
    issue(8'h80, 8'h01, 1'b0, 1);
    issue(8'h00, 8'h00, 1'b1, 1);

    // Result stall: outputs held, in_valid pulse ignored
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    st = model(8'h33, 8'h44, 1'b0);
    issue(8'h33, 8'h44, 1'b0, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("stall_reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready),  32'd0);
      check("stall_diff",     32'(diff),      32'(st.diff));
      check("stall_bout",     32'(bout),      32'(st.bout));
      check("stall_ovf",      32'(ovf),       32'(st.ovf));
      in_valid = (i == 1);
      a        = 8'hFF;
      b        = 8'h00;
      step();
    end
    in_valid = 1'b0;
    check("stall_pulse_ignored", 32'(busy), 32'd0);
    out_ready = 1'b1;
    step();
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_in_ready",  32'(in_ready),  32'd1);
    check("handoff_busy",      32'(busy),      32'd0);
    check("idle_retain_diff",  32'(diff),      32'(st.diff));

    // Reset mid-RUN aborts without a result
    issue(8'h5A, 8'h3C, 1'b0, 0);
    repeat (5) step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_diff",      32'(diff),      32'd0);
    step();
    step();
    rst = 1'b0;
    issue(8'h5A, 8'h3C, 1'b0, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("post_rst_diff", 32'(diff), 32'h1E);
    step();

    // Back-to-back random operands with random out_ready
    rand_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      step();
      n++;
    end
    rand_rdy  = 0;
    out_ready = 1'b1;
    check("drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have one parameter: WIDTH, default 8, giving the operand width in bits; legal range is 1 to 32.
REQ-003 The block SHALL have the following ports:
  clk        in   1      rising-edge clock
  rst        in   1      asynchronous, active-high reset
  in_valid   in   1      operand set valid
  in_ready   out  1      block can accept operands
  a          in   WIDTH  minuend, unsigned or two's complement
  b          in   WIDTH  subtrahend
  bin        in   1      borrow-in
  out_valid  out  1      result valid
  out_ready  in   1      consumer accepts result
  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
  bout       out  1      unsigned borrow-out
  ovf        out  1      two's-complement overflow
  busy       out  1      high while in the RUN state

Function
REQ-004 The block SHALL implement a three-state FSM: IDLE -> RUN on accept; RUN -> DONE after WIDTH bit-steps; DONE -> IDLE on out_valid && out_ready.
REQ-005 in_ready SHALL be 1 only in IDLE; an accept occurs on a rising edge where in_valid && in_ready.
REQ-006 On accept, the block SHALL latch a and b into shift registers and load bin into the borrow flip-flop; later changes on a, b and bin SHALL be ignored until the next accept.
REQ-007 In RUN, each edge SHALL process one bit, LSB first, through one full-subtractor cell: d = x^y^br; br_next = (~x&y) | (~(x^y)&br).
REQ-008 Each difference bit SHALL shift into diff from the MSB side, so that diff holds the full result after WIDTH steps.
REQ-009 A bit counter of width clog2(WIDTH+1) SHALL count RUN steps; the FSM SHALL enter DONE on the edge that processes bit WIDTH-1.
REQ-010 Latency: out_valid SHALL rise exactly WIDTH edges after the accept edge, and busy SHALL be high for exactly those WIDTH cycles.
REQ-011 bout SHALL equal the final borrow, i.e. 1 if and only if the unsigned value a < b + bin.
REQ-012 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-013 diff, bout and ovf SHALL be valid only while out_valid=1, and SHALL be held stable while out_valid && !out_ready.
REQ-014 When out_ready is already high on entry to DONE, the result SHALL be consumed on the first edge in DONE and the FSM SHALL return to IDLE.
REQ-015 No accept SHALL occur in the same cycle as a DONE->IDLE handoff; in_ready SHALL rise one cycle after the handoff.
REQ-016 in_valid asserted in RUN or DONE SHALL have no effect.
REQ-017 diff, bout and ovf SHALL retain the last result in IDLE until the next accept.
REQ-018 WIDTH=1 SHALL work: RUN lasts one cycle.

Reset
REQ-019 While rst=1, the block SHALL drive state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, bout=0, ovf=0, counter=0 and borrow=0; outputs SHALL change without waiting for a clock edge.
REQ-020 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered.
REQ-021 The first accept SHALL be possible on the first clk edge after rst deasserts.

Structure
REQ-022 A shared package serial_sub_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH constant.
REQ-023 The one-bit cell SHALL be a separate combinational sub-module full_subtractor (ports x, y, bin, d, bout), instantiated once.
REQ-024 All sequential logic SHALL sit in serial_subtractor, and no combinational path SHALL run from in_valid to in_ready or from out_ready to out_valid.

Verification
REQ-025 The bench SHALL cover the following directed scenarios, all at WIDTH=8:
  a=0x5A, b=0x3C, bin=0 -> diff=0x1E, bout=0, ovf=0, out_valid exactly 8 edges after accept.
  a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
  a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
  a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
  out_ready held 0 for 5 cycles in DONE, with in_valid pulsed meanwhile -> outputs stable, in_ready=0, pulse ignored; then out_ready=1 -> IDLE, in_ready=1 on the following cycle.
  rst asserted after bit 4 of a RUN -> out_valid=0, busy=0, in_ready=1 immediately; a fresh 0x5A-0x3C then yields 0x1E.
REQ-026 The bench SHALL also run back-to-back random operand sets against a reference model with out_ready toggling randomly.
